// File: rtl/mem_request_ctrl.sv
// Memory-stage controller: turns an execute-latch load/store into a
// registered data-cache request, holds it until dhit, returns load data,
// and keeps sticky halt/misalign flags plus a saturating stall counter.
module mem_request_ctrl #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ex_dREN,
    input  logic              ex_dWEN,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [ADDR_W-1:0] ex_wdat,
    input  logic              ex_halt,
    input  logic              dhit,
    input  logic [ADDR_W-1:0] dmemload,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [ADDR_W-1:0] dmemaddr,
    output logic [ADDR_W-1:0] dmemstore,
    output logic              mem_stall,
    output logic [ADDR_W-1:0] load_data,
    output logic              load_valid,
    output logic              misalign,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_cycles
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t state, state_next;
    logic   req;

    assign req = (ex_dREN | ex_dWEN) & ~halted;

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state and combinational stall
    always_comb begin
        state_next = state;
        mem_stall  = 1'b0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    mem_stall  = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                mem_stall = 1'b1;
                if (dhit) state_next = DONE;
            end
            DONE: begin
                // ex_* still shows the completed instruction here; req is ignored
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request issue/retire, load capture and sticky flags
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dmemREN    <= 1'b0;
            dmemWEN    <= 1'b0;
            dmemaddr   <= '0;
            dmemstore  <= '0;
            load_data  <= '0;
            load_valid <= 1'b0;
            misalign   <= 1'b0;
            halted     <= 1'b0;
        end else begin
            load_valid <= 1'b0;
            if (state == IDLE) begin
                if (req) begin
                    dmemaddr  <= {ex_addr[ADDR_W-1:2], 2'b00};
                    dmemstore <= ex_wdat;
                    dmemWEN   <= ex_dWEN;
                    dmemREN   <= ex_dREN & ~ex_dWEN;
                    if (ex_addr[1:0] != 2'b00) misalign <= 1'b1;
                end else if (ex_halt) begin
                    halted <= 1'b1;
                end
            end
            if (state == REQ && dhit) begin
                dmemREN <= 1'b0;
                dmemWEN <= 1'b0;
                // load_valid is registered, so it is high exactly in DONE
                if (dmemREN) begin
                    load_data  <= dmemload;
                    load_valid <= 1'b1;
                end
            end
        end
    end

    // Saturating count of stalled cycles
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)                               stall_cycles <= '0;
        else if (mem_stall && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
    end

endmodule
